// File: rtl/axi4l_write_slave_mem.sv
// AXI4-lite write slave into a word-addressed register file with byte strobes.
// States: COLLECT gather AW/W in any order | COMMIT decode and write | RESP hold B until accepted.
module axi4l_write_slave_mem #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      AW_ADDR,
    input  logic                       AW_VALID,
    output logic                       AW_READY,
    input  logic [DATA_WIDTH-1:0]      W_DATA,
    input  logic [DATA_WIDTH/8-1:0]    W_STRB,
    input  logic                       W_VALID,
    output logic                       W_READY,
    output logic [1:0]                 B_RESP,
    output logic                       B_VALID,
    input  logic                       B_READY,
    input  logic [$clog2(DEPTH)-1:0]   RD_IDX,
    output logic [DATA_WIDTH-1:0]      RD_DATA,
    output logic [31:0]                WR_COUNT
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * STRB_W);

    typedef enum logic [1:0] {S_COLLECT, S_COMMIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    aw_ready_q, aw_ready_d;
    logic                    w_ready_q, w_ready_d;
    logic                    b_valid_q, b_valid_d;
    logic [1:0]              b_resp_q, b_resp_d;
    logic [31:0]             wr_count_q, wr_count_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0]   offset;
    logic                    addr_err;
    logic [IDX_W-1:0]        wr_idx;
    logic                    mem_we;

    assign aw_hs    = AW_VALID & aw_ready_q;
    assign w_hs     = W_VALID & w_ready_q;
    // Addresses below the base wrap to a huge offset and fail the range test.
    assign offset   = addr_q - BASE_ADDR;
    assign addr_err = (offset[OFF_W-1:0] != '0) || (offset >= SPAN);
    assign wr_idx   = offset[OFF_W +: IDX_W];

    always_comb begin
        state_d    = state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strb_d     = strb_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        unique case (state_q)
            S_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    addr_d    = AW_ADDR;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    data_d   = W_DATA;
                    strb_d   = W_STRB;
                end
                if (aw_held_d && w_held_d) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                b_valid_d = 1'b1;
                state_d   = S_RESP;
                if (addr_err) begin
                    b_resp_d = 2'b10;
                end else begin
                    b_resp_d   = 2'b00;
                    mem_we     = 1'b1;
                    wr_count_d = wr_count_q + 32'd1;
                end
            end
            S_RESP: begin
                if (B_READY) begin
                    state_d   = S_COLLECT;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    b_valid_d = 1'b0;
                end
            end
            default: state_d = S_COLLECT;
        endcase
        // Readies are registered from the next state so they stay low through reset.
        aw_ready_d = (state_d == S_COLLECT) && !aw_held_d;
        w_ready_d  = (state_d == S_COLLECT) && !w_held_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_COLLECT;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= 2'b00;
            wr_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            wr_count_q <= wr_count_d;
            if (mem_we) begin
                for (int i = 0; i < STRB_W; i++) begin
                    if (strb_q[i]) mem_q[wr_idx][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end

    assign AW_READY = aw_ready_q;
    assign W_READY  = w_ready_q;
    assign B_VALID  = b_valid_q;
    assign B_RESP   = b_resp_q;
    assign WR_COUNT = wr_count_q;
    assign RD_DATA  = mem_q[RD_IDX];

endmodule

// File: tb/tb_axi4l_write_slave_mem.sv
// Bench for axi4l_write_slave_mem: scoreboarded B responses plus a byte-lane memory model.
module tb_axi4l_write_slave_mem;
    localparam int          DEPTH = 16;
    localparam logic [63:0] BASE  = 64'h1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] AW_ADDR = '0;
    logic        AW_VALID = 1'b0;
    logic        AW_READY;
    logic [63:0] W_DATA = '0;
    logic [7:0]  W_STRB = '0;
    logic        W_VALID = 1'b0;
    logic        W_READY;
    logic [1:0]  B_RESP;
    logic        B_VALID;
    logic        B_READY = 1'b1;
    logic [3:0]  RD_IDX = '0;
    logic [63:0] RD_DATA;
    logic [31:0] WR_COUNT;

    always #5 clk = ~clk;

    axi4l_write_slave_mem #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .RD_IDX(RD_IDX), .RD_DATA(RD_DATA), .WR_COUNT(WR_COUNT)
    );

    int          n_err = 0;
    int          n_chk = 0;
    logic [1:0]  exp_q [$];
    logic [63:0] model_mem [DEPTH];
    logic [31:0] model_cnt = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && B_VALID && B_READY) begin
            if (exp_q.size() == 0) check_val("b_unexpected", 64'(exp_q.size()), 64'd1);
            else check_val("b_resp", 64'(B_RESP), 64'(exp_q.pop_front()));
        end
    end

    task automatic model_write(input logic [63:0] addr, input logic [63:0] data,
                               input logic [7:0] strb, output logic [1:0] resp);
        logic [63:0] off;
        off = addr - BASE;
        if (off[2:0] != 3'd0 || off >= 64'(DEPTH * 8)) begin
            resp = 2'b10;
        end else begin
            for (int i = 0; i < 8; i++)
                if (strb[i]) model_mem[off[6:3]][8*i +: 8] = data[8*i +: 8];
            model_cnt++;
            resp = 2'b00;
        end
    endtask

    task automatic check_mem();
        for (int i = 0; i < DEPTH; i++) begin
            RD_IDX = 4'(i);
            #1;
            check_val($sformatf("mem%0d", i), RD_DATA, model_mem[i]);
        end
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; bstall: cycles B_READY stays low.
    task automatic write_txn(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb, input int lead, input int bstall);
        int          n;
        logic [63:0] off;
        logic [63:0] old_word;
        logic [1:0]  resp;
        n   = (lead < 0) ? -lead : lead;
        off = addr - BASE;
        RD_IDX  = off[6:3];
        B_READY = (bstall == 0);
        @(negedge clk);
        check_val("idle_bvalid", 64'(B_VALID), 64'd0);
        check_val("idle_ready", 64'({AW_READY, W_READY}), 64'd3);
        if (lead >= 0) begin W_VALID = 1'b1; W_DATA = data; W_STRB = strb; end
        if (lead <= 0) begin AW_VALID = 1'b1; AW_ADDR = addr; end
        @(posedge clk); #1;
        if (lead >= 0) begin W_VALID = 1'b0; W_DATA = ~data; W_STRB = ~strb; end
        if (lead <= 0) begin AW_VALID = 1'b0; AW_ADDR = ~addr; end
        if (lead != 0) begin
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                if (k == 0)
                    check_val("held_ready", 64'({AW_READY, W_READY}), (lead > 0) ? 64'd2 : 64'd1);
            end
            if (lead > 0) begin AW_VALID = 1'b1; AW_ADDR = addr; end
            else begin W_VALID = 1'b1; W_DATA = data; W_STRB = strb; end
            @(posedge clk); #1;
            if (lead > 0) begin AW_VALID = 1'b0; AW_ADDR = ~addr; end
            else begin W_VALID = 1'b0; W_DATA = ~data; W_STRB = ~strb; end
        end
        old_word = model_mem[off[6:3]];
        model_write(addr, data, strb, resp);
        exp_q.push_back(resp);
        @(negedge clk);
        check_val("commit_bvalid", 64'(B_VALID), 64'd0);
        check_val("commit_ready", 64'({AW_READY, W_READY}), 64'd0);
        check_val("commit_rd_old", RD_DATA, old_word);
        @(negedge clk);
        check_val("resp_bvalid", 64'(B_VALID), 64'd1);
        check_val("resp_rd_new", RD_DATA, model_mem[off[6:3]]);
        check_val("resp_count", 64'(WR_COUNT), 64'(model_cnt));
        if (bstall > 0) begin
            AW_VALID = 1'b1;
            AW_ADDR  = BASE + 64'h20;
            for (int k = 0; k < bstall; k++) begin
                if (k > 0) @(negedge clk);
                check_val("stall_bvalid", 64'(B_VALID), 64'd1);
                check_val("stall_bresp", 64'(B_RESP), 64'(resp));
                check_val("stall_ready", 64'({AW_READY, W_READY}), 64'd0);
            end
            @(posedge clk); #1;
            B_READY  = 1'b1;
            AW_VALID = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        repeat (3) @(negedge clk);
        check_val("rst_aw_ready", 64'(AW_READY), 64'd0);
        check_val("rst_w_ready", 64'(W_READY), 64'd0);
        check_val("rst_bvalid", 64'(B_VALID), 64'd0);
        check_val("rst_bresp", 64'(B_RESP), 64'd0);
        check_val("rst_count", 64'(WR_COUNT), 64'd0);
        check_val("rst_rd_data", RD_DATA, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rel_ready_low", 64'({AW_READY, W_READY}), 64'd0);
        @(negedge clk);
        check_val("rel_ready_high", 64'({AW_READY, W_READY}), 64'd3);

        write_txn(BASE + 64'h8, 64'h1122334455667788, 8'hFF, 0, 0);
        RD_IDX = 4'd1; #1;
        check_val("tp_simul_word1", RD_DATA, 64'h1122334455667788);
        check_val("tp_simul_count", 64'(WR_COUNT), 64'd1);

        write_txn(BASE + 64'h8, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 3, 0);
        RD_IDX = 4'd1; #1;
        check_val("tp_wfirst_word1", RD_DATA, 64'h11223344AAAAAAAA);

        write_txn(BASE + 64'h4, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, 0);
        write_txn(BASE + 64'(DEPTH * 8), 64'h0123456789ABCDEF, 8'hFF, 0, 0);
        write_txn(BASE - 64'h8, 64'h0123456789ABCDEF, 8'hFF, -1, 0);
        check_val("tp_err_count", 64'(WR_COUNT), 64'd2);
        write_txn(BASE + 64'h78, 64'hCAFEF00DCAFEF00D, 8'hF0, -2, 0);
        write_txn(BASE + 64'h18, 64'hFFFFFFFFFFFFFFFF, 8'h00, 1, 0);
        write_txn(BASE + 64'h20, 64'h5555666677778888, 8'h3C, 0, 5);
        check_mem();

        for (int r = 0; r < 10; r++) begin
            a = BASE + 64'($urandom_range(0, 19)) * 64'd8;
            if ($urandom_range(0, 4) == 0) a = a + 64'h4;
            d = {$urandom, $urandom};
            write_txn(a, d, 8'($urandom_range(0, 255)), int'($urandom_range(0, 4)) - 2, 0);
        end
        check_mem();

        @(negedge clk);
        B_READY = 1'b0;
        RD_IDX  = 4'd2;
        AW_VALID = 1'b1; AW_ADDR = BASE + 64'h10;
        W_VALID  = 1'b1; W_DATA = 64'h0F0F0F0F0F0F0F0F; W_STRB = 8'hFF;
        @(posedge clk); #1;
        AW_VALID = 1'b0; W_VALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rstresp_bvalid", 64'(B_VALID), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_cnt = '0;
        check_val("rstresp_bvalid_low", 64'(B_VALID), 64'd0);
        check_val("rstresp_count", 64'(WR_COUNT), 64'd0);
        check_val("rstresp_ready", 64'({AW_READY, W_READY}), 64'd0);
        check_mem();
        @(posedge clk); #1;
        rst = 1'b0;
        B_READY = 1'b1;
        @(negedge clk);
        check_val("rstrel_ready_low", 64'({AW_READY, W_READY}), 64'd0);
        @(negedge clk);
        check_val("rstrel_ready_high", 64'({AW_READY, W_READY}), 64'd3);

        write_txn(BASE, 64'h0102030405060708, 8'hFF, 0, 0);
        check_mem();
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
